// File: rtl/serial_frame_pkg.sv
// Shared definitions for the one-bit framed serial line: frame states and line levels.
// Used by the transmitter and the planned receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } frame_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bit-counter width: at least one bit even for a one-bit word.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// N-bit parallel-load shift register; presents the next bit to send on bit_out.
// Shift direction follows LSB_FIRST so bit_out is always the next data bit.
module piso_shift_reg #(
    parameter int N         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_ah_in,
    input  logic         load_in,
    input  logic         shift_in,
    input  logic [N-1:0] d_in,
    output logic         bit_out
);

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_in) begin
            sr_d = d_in;
        end else if (shift_in) begin
            sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_ah_in) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_out = LSB_FIRST ? sr_q[0] : sr_q[N-1];

endmodule

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: start bit, N data bits, stop bit; line idles high.
// Outputs are registered from the next state so the start bit follows the accept edge.
module piso_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int N         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_ah_in,
    input  logic [N-1:0] d_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         q_out,
    output logic         busy_out,
    output logic         done_out
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    frame_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          sr_shift;
    logic          sr_bit;

    // STOP also accepts so that a held valid_in gives gap-free back-to-back frames.
    assign ready_out = ~reset_ah_in & ((state_q == IDLE) | (state_q == STOP));
    assign accept    = valid_in & ready_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = STOP;
            end
            STOP: begin
                state_d = accept ? START : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The shifter pops one bit on every edge that lands in DATA, including entry from START.
    assign sr_shift = (state_d == DATA);

    always_comb begin
        q_d = LINE_IDLE;
        case (state_d)
            START:   q_d = START_BIT;
            DATA:    q_d = sr_bit;
            STOP:    q_d = STOP_BIT;
            default: q_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP);
    end

    always_ff @(posedge clk) begin
        if (reset_ah_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    piso_shift_reg #(
        .N         (N),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .reset_ah_in (reset_ah_in),
        .load_in     (accept),
        .shift_in    (sr_shift),
        .d_in        (d_in),
        .bit_out     (sr_bit)
    );

    assign q_out    = q_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: LSB-first and MSB-first instances share one stimulus stream.
// A frame-position model predicts accepts and line levels; a line decoder rebuilds words for the scoreboard.
module tb_piso_frame_tx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_ah_in;
    logic [N-1:0] d_in;
    logic         valid_in;
    logic         ready_o [2];
    logic         q_o     [2];
    logic         busy_o  [2];
    logic         done_o  [2];

    int errors = 0;
    int checks = 0;

    string nm [2] = '{"lsb", "msb"};

    always #5 clk = ~clk;

    piso_frame_tx #(.N(N), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset_ah_in(reset_ah_in), .d_in(d_in), .valid_in(valid_in),
        .ready_out(ready_o[0]), .q_out(q_o[0]), .busy_out(busy_o[0]), .done_out(done_o[0])
    );

    piso_frame_tx #(.N(N), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset_ah_in(reset_ah_in), .d_in(d_in), .valid_in(valid_in),
        .ready_out(ready_o[1]), .q_out(q_o[1]), .busy_out(busy_o[1]), .done_out(done_o[1])
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pos = -1 idle, 0 start bit, 1..N data bits, N+1 stop bit.
    int           pos      = -1;
    logic [N-1:0] cur_w    = '0;
    bit           armed    = 1'b0;
    bit           acc_flag = 1'b0;
    logic         exp_q;
    logic [N-1:0] expq0 [$];
    logic [N-1:0] expq1 [$];

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                if (pos < 0 || pos == N + 1) exp_q = 1'b1;
                else if (pos == 0)           exp_q = 1'b0;
                else                         exp_q = (d == 0) ? cur_w[pos-1] : cur_w[N-pos];
                check_bit($sformatf("q_out_%s", nm[d]), q_o[d], exp_q);
                check_bit($sformatf("busy_out_%s", nm[d]), busy_o[d], pos >= 0);
                check_bit($sformatf("done_out_%s", nm[d]), done_o[d], pos == N + 1);
                check_bit($sformatf("ready_out_%s", nm[d]), ready_o[d],
                          !reset_ah_in && (pos < 0 || pos == N + 1));
            end
        end
        if (reset_ah_in) begin
            armed = 1'b1;
            if (pos >= 0 && pos <= N) begin
                if (expq0.size() > 0) void'(expq0.pop_back());
                if (expq1.size() > 0) void'(expq1.pop_back());
            end
            pos      = -1;
            acc_flag = 1'b0;
        end else begin
            acc_flag = valid_in && (pos < 0 || pos == N + 1);
            if (acc_flag) begin
                pos   = 0;
                cur_w = d_in;
                expq0.push_back(d_in);
                expq1.push_back(d_in);
            end else if (pos >= 0 && pos <= N) begin
                pos++;
            end else begin
                pos = -1;
            end
        end
    end

    // Line decoder / scoreboard: rebuild each frame from q_out and compare against the queue.
    int           mpos  [2] = '{-1, -1};
    logic [N-1:0] mword [2];
    logic [N-1:0] popped;
    int           idx;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mpos[d] < 0) begin
                if (q_o[d] === 1'b0) mpos[d] = 1;
            end else if (mpos[d] <= N) begin
                idx = (d == 0) ? (mpos[d] - 1) : (N - mpos[d]);
                mword[d][idx] = q_o[d];
                mpos[d]++;
            end else begin
                check_bit($sformatf("stop_bit_%s", nm[d]), q_o[d], 1'b1);
                checks++;
                if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
                    errors++;
                    $display("FAIL spurious_frame_%s: got word %h expected no frame at %0t",
                             nm[d], mword[d], $time);
                end else begin
                    checks--;
                    popped = (d == 0) ? expq0.pop_front() : expq1.pop_front();
                    check_word($sformatf("frame_word_%s", nm[d]), mword[d], popped);
                end
                mpos[d] = -1;
            end
            if (reset_ah_in) mpos[d] = -1;
        end
    end

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] w, input bit hold);
        bit got = 1'b0;
        d_in     = w;
        valid_in = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk);
            got = acc_flag;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %h at %0t", w, $time);
        end
        #1;
        if (!hold) valid_in = 1'b0;
    endtask

    initial begin
        reset_ah_in = 1'b1;
        valid_in    = 1'b0;
        d_in        = '0;
        idle(3);
        reset_ah_in = 1'b0;
        idle(5);

        // single frames, both bit orders
        send(4'b1011, 1'b0);
        idle(8);

        // back-to-back with valid held high
        send(4'hA, 1'b1);
        send(4'h5, 1'b0);
        idle(8);

        // reset during the third data bit, then a clean frame
        send(4'hF, 1'b0);
        idle(3);
        reset_ah_in = 1'b1;
        idle(1);
        reset_ah_in = 1'b0;
        idle(2);
        send(4'h0, 1'b0);
        idle(8);

        // valid and data activity while a frame is in flight
        send(4'h3, 1'b0);
        idle(2);
        d_in     = 4'hC;
        valid_in = 1'b1;
        idle(1);
        valid_in = 1'b0;
        d_in     = 4'h9;
        idle(8);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset_ah_in = ($urandom_range(0, 79) == 0);
            valid_in    = ($urandom_range(0, 3) != 0);
            d_in        = N'($urandom);
            idle(1);
        end
        reset_ah_in = 1'b0;
        valid_in    = 1'b0;
        idle(12);

        checks++;
        if (expq0.size() != 0 || expq1.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0",
                     expq0.size(), expq1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
Parallel-in, serial-out framed transmitter: the sending end of the one-bit serial line that the team's shift-register chain carries.
- Accepts an N-bit word through a valid/ready handshake.
- Drives it onto one serial line as a frame: start bit (0), N data bits, stop bit (1).
- Line idles high.
- Sits upstream of the SISO delay chain and the future serial receiver.

Parameters:
N, 4, data word width in bits (N >= 1)
LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = data bit N-1 sent first

Ports:
clk  input  1  system clock, all logic on rising edge
reset_ah_in  input  1  synchronous reset, active-high
d_in  input  N  parallel word to transmit
valid_in  input  1  d_in holds a word to send
ready_out  input/output: output  1  block can accept a word this cycle
q_out  output  1  serial line, registered
busy_out  output  1  a frame is in progress (START, DATA or STOP)
done_out  output  1  one-cycle pulse during the stop-bit cycle

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_ah_in` is synchronous and active-high, and takes priority over every other input.
- Reset values: state=IDLE, q_out=1, busy_out=0, done_out=0, bit counter=0, shift register=0.
- ready_out during reset: forced to 0 while reset_ah_in=1; no handshake completes.
- States:
  - IDLE: q_out=1.
  - START: q_out=0 for 1 cycle.
  - DATA: q_out=current data bit for N cycles.
  - STOP: q_out=1 for 1 cycle.
- ready_out = ~reset_ah_in & (state==IDLE | state==STOP), combinational.
- Accept: the rising edge where valid_in & ready_out. On that edge:
  - d_in is captured into the shift register.
  - The next state is START.
- Transitions:
  - IDLE -> START on accept; otherwise stay in IDLE.
  - START -> DATA unconditionally; counter cleared to 0.
  - DATA: shift one bit per cycle and increment the counter. At counter==N-1, go to STOP.
  - STOP -> START if accept on this edge (back-to-back); otherwise go to IDLE.
- Frame length: N+2 cycles. Sustained throughput is one word per N+2 cycles, with no idle gap when valid_in is held high.
- Latency: the start bit appears on q_out in the cycle immediately after the accept edge, since q_out is registered from the next state.
- Bit order:
  - LSB_FIRST=1: first data cycle carries d[0], last carries d[N-1].
  - LSB_FIRST=0: order reversed.
- d_in is ignored outside accept edges. A change in d_in mid-frame does not affect the frame in flight.
- valid_in while busy (START or DATA): ignored; ready_out=0. The upstream block must hold valid_in until ready_out.
- busy_out=1 in START, DATA and STOP.
- done_out=1 in the STOP cycle only, including when STOP is followed directly by START.
- Reset mid-frame: on the next edge, the frame is abandoned, q_out returns to 1 and state goes to IDLE. No done_out is issued.
- Counter width: max(1, clog2(N)). For N=1, DATA lasts exactly 1 cycle.

Decomposition:
- Shared package/header `serial_frame_pkg`, shared with the planned receiver. It holds:
  - State encodings IDLE/START/DATA/STOP (2-bit).
  - Constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- Optional sub-module `piso_shift_reg` (N-bit, parallel load, shift direction set by LSB_FIRST). The FSM and bit counter stay in the top module.

Test Plan:
1. N=4, LSB_FIRST=1. After reset, hold valid_in=0 for 5 cycles -> q_out=1, ready_out=1, busy_out=0, done_out=0 throughout.
2. N=4, LSB_FIRST=1, d_in=4'b1011, valid_in pulsed for 1 cycle -> q_out over the next 6 cycles = 0,1,1,0,1,1. done_out=1 only on cycle 6, then q_out stays 1.
3. N=4, LSB_FIRST=0, d_in=4'b1011 -> q_out = 0,1,0,1,1,1.
4. Back-to-back: valid_in held high with 4'hA then 4'h5 (LSB_FIRST=1):
   - Expected q_out: 0,0,1,0,1,1 then 0,1,0,1,0,1 with no idle cycle between frames.
   - ready_out=1 only in cycles 6 and 12.
5. Reset mid-frame: assert reset_ah_in during the 3rd data bit of 4'hF -> the next cycle has q_out=1, busy_out=0, no done_out. A new word 4'h0 sends cleanly afterwards.
6. Busy blocking: during a frame of 4'h3, toggle d_in and pulse valid_in -> the frame still carries 4'h3, ready_out=0 throughout START/DATA, and no extra frame is sent.
